instr_receiver: RTL

INSTR_RECEIVER -- requirements
Module: instr_receiver

---
 rtl/instr_pkg.sv | 17 +
 rtl/input_sync.sv | 31 +++
 rtl/instr_receiver.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// Shared definitions for the MBED instruction receiver.
// Holds the default instruction width and timeout, and the FSM state encoding.
// The state values are fixed because instr_state drives debug LEDs.
package instr_pkg;

   localparam int unsigned INSTR_WIDTH_DEF    = 10;
   // 100 ms at 24 MHz
   localparam int unsigned TIMEOUT_CYCLES_DEF = 2_400_000;

   typedef enum logic [1:0] {
      S_WAIT   = 2'd0,
      S_ACK    = 2'd1,
      S_COMMIT = 2'd2,
      S_DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/input_sync.sv
// Multi-flop synchroniser for a single asynchronous input bit.
// Ports:
//   clk      - destination clock
//   rst_n    - asynchronous active-low reset; clears every stage to 0
//   async_in - input from the foreign clock domain
//   sync_out - copy of async_in delayed by STAGES rising edges
module input_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= async_in;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/instr_receiver.sv
// Receives MSB-first instruction words from the MBED over a 4-phase
// data_ready/data_ack handshake and presents them to the servo sequencer.
// Ports:
//   clk               - system clock
//   reset             - asynchronous active-low reset
//   data_ready        - MBED bit strobe (asynchronous)
//   data_bit          - MBED serial data (asynchronous, stable while data_ready high)
//   clear             - consumer releases the current instruction
//   data_ack          - per-bit acknowledge back to the MBED
//   servo_instr       - last complete instruction word
//   instruction_ready - servo_instr valid and not yet consumed
//   frame_error       - one-cycle pulse when a partial frame times out
//   instr_state       - FSM state, for debug LEDs
module instr_receiver
   import instr_pkg::*;
#(
   parameter int unsigned INSTR_WIDTH    = INSTR_WIDTH_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   data_ready,
   input  logic                   data_bit,
   input  logic                   clear,
   output logic                   data_ack,
   output logic [INSTR_WIDTH-1:0] servo_instr,
   output logic                   instruction_ready,
   output logic                   frame_error,
   output logic [1:0]             instr_state
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned BitW = $clog2(INSTR_WIDTH + 1);
   localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);
   localparam logic [BitW-1:0] FullCount  = BitW'(INSTR_WIDTH);

   // Reset asserts immediately, releases two edges after the pin rises.
   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[1];

   logic ready_s;
   logic bit_s;

   input_sync #(
      .STAGES(SYNC_STAGES)
   ) u_sync_ready (
      .clk     (clk),
      .rst_n   (rst_int_n),
      .async_in(data_ready),
      .sync_out(ready_s)
   );

   input_sync #(
      .STAGES(SYNC_STAGES)
   ) u_sync_bit (
      .clk     (clk),
      .rst_n   (rst_int_n),
      .async_in(data_bit),
      .sync_out(bit_s)
   );

   state_e                 state_q, state_d;
   logic [INSTR_WIDTH-1:0] shift_q, shift_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [BitW-1:0]        count_q, count_d;
   logic [CntW-1:0]        timer_q, timer_d, timer_inc;
   logic                   valid_q, valid_d;
   logic                   ack_q, ack_d;
   logic                   ferr_q, ferr_d;
   logic                   armed_q, armed_d;
   logic                   timer_run;
   logic                   timeout;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      instr_d = instr_q;
      count_d = count_q;
      valid_d = valid_q;
      ferr_d  = 1'b0;
      armed_d = armed_q;

      // Only a partial frame is timed; an idle line may stay idle forever.
      timer_run = (state_q == S_ACK) || ((state_q == S_WAIT) && (count_q != '0));
      timer_inc = (timer_q == TimeoutVal) ? timer_q : timer_q + CntW'(1);
      timeout   = timer_run && (timer_inc == TimeoutVal);

      // A new bit needs synced data_ready to have been low since the last accept.
      if (!ready_s) begin
         armed_d = 1'b1;
      end

      unique case (state_q)
         S_WAIT: begin
            if (ready_s && armed_q) begin
               shift_d = (shift_q << 1) | INSTR_WIDTH'(bit_s);
               count_d = count_q + BitW'(1);
               armed_d = 1'b0;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            if (!ready_s) begin
               state_d = (count_q == FullCount) ? S_COMMIT : S_WAIT;
            end
         end
         S_COMMIT: begin
            instr_d = shift_q;
            valid_d = 1'b1;
            count_d = '0;
            shift_d = '0;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (clear) begin
               valid_d = 1'b0;
               state_d = S_WAIT;
            end
         end
         default: state_d = S_WAIT;
      endcase

      // Abort overrides any same-cycle accept or ack release.
      if (timeout) begin
         state_d = S_WAIT;
         shift_d = '0;
         count_d = '0;
         ferr_d  = 1'b1;
         armed_d = armed_q | ~ready_s;
      end

      timer_d = ((state_d != state_q) || timeout || !timer_run) ? '0 : timer_inc;
      ack_d   = (state_d == S_ACK);
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q <= S_WAIT;
         shift_q <= '0;
         instr_q <= '0;
         count_q <= '0;
         timer_q <= '0;
         valid_q <= 1'b0;
         ack_q   <= 1'b0;
         ferr_q  <= 1'b0;
         armed_q <= 1'b1;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         instr_q <= instr_d;
         count_q <= count_d;
         timer_q <= timer_d;
         valid_q <= valid_d;
         ack_q   <= ack_d;
         ferr_q  <= ferr_d;
         armed_q <= armed_d;
      end
   end

   assign data_ack          = ack_q;
   assign servo_instr       = instr_q;
   assign instruction_ready = valid_q;
   assign frame_error       = ferr_q;
   assign instr_state       = state_q;

endmodule
